riscv_imem_loader: RTL and testbench
====================================

// Module: riscv_imem_loader
// PURPOSE
//  Encoder/writer counterpart of the instruction decode path: accepts field-level instructions
//  (format, opcode, rd, rs1, rs2, funct3, funct7, full immediate) over a valid/ready stream.
//  Packs each one into the RV32I 32-bit word, range-checks the immediate, and writes words to
//  consecutive word-aligned byte addresses of instruction memory. Used for program preload/self-test.
// PARAMETERS
//  MEM_SIZE  128               memory size in bytes (riscv_defs)
//  NB_ADDR   $clog2(MEM_SIZE)  byte-address width
//  NB_WORD   32                instruction width
// PORTS
//  clk          in   1        clock, single domain
//  rst_n        in   1        synchronous active-low reset
//  i_start      in   1        pulse: begin new load at i_base_addr
//  i_base_addr  in   NB_ADDR  first byte address; bits[1:0] ignored (forced 0)
//  s_valid      in   1        instruction fields valid
//  s_ready      out  1        loader accepts this cycle
//  s_last       in   1        marks final instruction of program
//  s_fmt        in   3        format: 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  s_opcode     in   7        opcode field
//  s_rd, s_rs1, s_rs2  in  5  register fields
//  s_funct3     in   3        funct3
//  s_funct7     in   7        funct7 (R; I-type shifts)
//  s_imm        in   32       immediate as signed byte value (not pre-shifted)
//  o_mem_we     out  1        write strobe
//  o_mem_addr   out  NB_ADDR  byte address, [1:0]=0
//  o_mem_wdata  out  32       encoded instruction
//  o_count      out  NB_ADDR-1 words written since start
//  o_done / o_full / o_err  out 1 each  status flags (sticky until i_start or reset)
// BEHAVIOUR
//  Reset: state IDLE; s_ready,o_mem_we,o_done,o_full,o_err=0; o_mem_addr,o_mem_wdata,o_count=0.
//  FSM IDLE->(i_start)->LOAD; LOAD->(s_last accepted)->DONE; LOAD->(top word written)->FULL;
//   DONE/FULL->(i_start)->LOAD. i_start in any state: address=base, count=0, flags cleared.
//  s_ready=1 only in LOAD and not (i_start this cycle). Accept = s_valid & s_ready.
//  Latency 1: accepted fields registered; o_mem_we/addr/wdata valid next cycle, one-cycle we pulse.
//  Write presented during the i_start cycle still completes; start takes effect next cycle.
//  Encoding: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op};
//   I-shift (op=0010011, f3=001/101) {f7,imm[4:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op};
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Range errors (no write, o_err=1, address/count unchanged, load continues):
//   I/S: imm not sign-ext of 12 bits; I-shift: imm>31; B: not 13-bit signed or imm[0]=1;
//   J: not 21-bit signed or imm[0]=1; U: imm[11:0]!=0; fmt 6/7 illegal.
//  s_last on an errored instruction still ends load (DONE, o_done=1).
//  Address advances +4 per write; write at MEM_SIZE-4 -> FULL, o_full=1, s_ready=0 (no wrap).
//   If that word also has s_last: DONE and o_full both set.
//  o_done asserts cycle after final write (or after errored last accept).
//  Reset mid-load: pending write dropped, all to reset values.
// STRUCTURE
//  riscv_defs additions: instr_fmt_t enum {FMT_R..FMT_J}, loader_state_t enum {IDLE,LOAD,DONE,FULL}.
//  Reuse r/i/s/b/u/j_type_t and instruction_t unions to pack words.
//  Sub-module riscv_instr_encoder: combinational fields->{word,err}; loader holds FSM/counters.
// TESTING
//  1 start base 0; I addi x1,x0,5 (op 0010011,f3 0,imm 5) -> we@addr 0x00, wdata 0x00500093.
//  2 S sw x2,-4(x1) (f3 010,imm -4) -> wdata 0xFE20AE23 at next addr 0x04, o_count=2.
//  3 B beq x0,x0,-8 -> 0xFE000CE3; J jal x1,8 -> 0x008000EF; B imm 4096 -> o_err=1, no we.
//  4 base 0x78, two words, valid held -> writes 0x78,0x7C; o_full=1, s_ready=0 thereafter.
//  5 s_last on 3rd word -> o_done=1 next cycle, s_ready=0; i_start clears flags, count=0.
//  6 rst_n low mid-load with pending accept -> no we next cycle, all outputs reset values.

Source files
------------

// File: rtl/riscv_imem_loader_pkg.sv
// Shared types for the instruction-memory loader: field bundle, RV32I word layouts, FSM states.
// Latency: none (types, constants and one pure helper function only).
// Backpressure: not applicable.
package riscv_imem_loader_pkg;

  localparam int DEF_MEM_SIZE = 128;
  localparam int NB_WORD      = 32;

  // OP-IMM opcode and the funct3 values that turn it into a shift-immediate
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRX     = 3'b101;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    FULL = 2'd3
  } loader_state_t;

  // Field-level instruction as it arrives on the input stream
  typedef struct packed {
    instr_fmt_t  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm_11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_4_0;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic       imm_12;
    logic [5:0] imm_10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm_4_1;
    logic       imm_11;
    logic [6:0] opcode;
  } b_type_t;

  typedef struct packed {
    logic [19:0] imm_31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef struct packed {
    logic       imm_20;
    logic [9:0] imm_10_1;
    logic       imm_11;
    logic [7:0] imm_19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_type_t;

  typedef union packed {
    r_type_t     r;
    i_type_t     i;
    s_type_t     s;
    b_type_t     b;
    u_type_t     u;
    j_type_t     j;
    logic [31:0] raw;
  } instruction_t;

  // True when v is the sign extension of its low nb bits
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nb);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (nb - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/riscv_imem_loader_encoder.sv
// Packs field-level instruction into an RV32I word and flags out-of-range immediates / bad format.
// Latency: purely combinational.
// Backpressure: none; the loader decides whether the word is written.
module riscv_instr_encoder
  import riscv_imem_loader_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          err
);

  instruction_t instr;
  logic         is_shift;

  // Shift-immediates reuse the R layout: funct7 on top, shamt in the rs2 slot
  always_comb begin
    is_shift = (fields.fmt == FMT_I) && (fields.opcode == OPC_OP_IMM) &&
               ((fields.funct3 == F3_SLL) || (fields.funct3 == F3_SRX));
  end

  // Per-format packing and immediate range check
  always_comb begin
    instr.raw = '0;
    err       = 1'b0;
    case (fields.fmt)
      FMT_R: begin
        instr.r.funct7 = fields.funct7;
        instr.r.rs2    = fields.rs2;
        instr.r.rs1    = fields.rs1;
        instr.r.funct3 = fields.funct3;
        instr.r.rd     = fields.rd;
        instr.r.opcode = fields.opcode;
      end
      FMT_I: begin
        if (is_shift) begin
          instr.r.funct7 = fields.funct7;
          instr.r.rs2    = fields.imm[4:0];
          instr.r.rs1    = fields.rs1;
          instr.r.funct3 = fields.funct3;
          instr.r.rd     = fields.rd;
          instr.r.opcode = fields.opcode;
          err            = |fields.imm[31:5];
        end else begin
          instr.i.imm_11_0 = fields.imm[11:0];
          instr.i.rs1      = fields.rs1;
          instr.i.funct3   = fields.funct3;
          instr.i.rd       = fields.rd;
          instr.i.opcode   = fields.opcode;
          err              = !fits_signed(fields.imm, 12);
        end
      end
      FMT_S: begin
        instr.s.imm_11_5 = fields.imm[11:5];
        instr.s.rs2      = fields.rs2;
        instr.s.rs1      = fields.rs1;
        instr.s.funct3   = fields.funct3;
        instr.s.imm_4_0  = fields.imm[4:0];
        instr.s.opcode   = fields.opcode;
        err              = !fits_signed(fields.imm, 12);
      end
      FMT_B: begin
        instr.b.imm_12   = fields.imm[12];
        instr.b.imm_10_5 = fields.imm[10:5];
        instr.b.rs2      = fields.rs2;
        instr.b.rs1      = fields.rs1;
        instr.b.funct3   = fields.funct3;
        instr.b.imm_4_1  = fields.imm[4:1];
        instr.b.imm_11   = fields.imm[11];
        instr.b.opcode   = fields.opcode;
        err              = !fits_signed(fields.imm, 13) || fields.imm[0];
      end
      FMT_U: begin
        instr.u.imm_31_12 = fields.imm[31:12];
        instr.u.rd        = fields.rd;
        instr.u.opcode    = fields.opcode;
        err               = |fields.imm[11:0];
      end
      FMT_J: begin
        instr.j.imm_20    = fields.imm[20];
        instr.j.imm_10_1  = fields.imm[10:1];
        instr.j.imm_11    = fields.imm[11];
        instr.j.imm_19_12 = fields.imm[19:12];
        instr.j.rd        = fields.rd;
        instr.j.opcode    = fields.opcode;
        err               = !fits_signed(fields.imm, 21) || fields.imm[0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  assign word = instr.raw;

endmodule

// File: rtl/riscv_imem_loader.sv
// Streams field-level instructions into consecutive instruction-memory words with status flags.
// Latency: 1 cycle from accept to the o_mem_we pulse carrying address and encoded word.
// Backpressure: s_ready high only while LOADing and not during i_start; drops when done or memory full.
module riscv_imem_loader
  import riscv_imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int NB_ADDR  = $clog2(MEM_SIZE),
  parameter int NB_WORD  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_base_addr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [2:0]         s_fmt,
  input  logic [6:0]         s_opcode,
  input  logic [4:0]         s_rd,
  input  logic [4:0]         s_rs1,
  input  logic [4:0]         s_rs2,
  input  logic [2:0]         s_funct3,
  input  logic [6:0]         s_funct7,
  input  logic [31:0]        s_imm,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_WORD-1:0] o_mem_wdata,
  output logic [NB_ADDR-2:0] o_count,
  output logic               o_done,
  output logic               o_full,
  output logic               o_err
);

  localparam logic [NB_ADDR-1:0] TOP_ADDR  = NB_ADDR'(MEM_SIZE - 4);
  localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(4);
  localparam logic [NB_ADDR-1:0] ALIGN_MSK = ~NB_ADDR'(3);

  loader_state_t      state_q;
  loader_state_t      state_d;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_ADDR-1:0] base_aligned;
  instr_fields_t      fields;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic               accept;
  logic               write_ok;
  logic               at_top;

  // Gather the input stream fields into one bundle for the encoder
  always_comb begin
    fields        = '0;
    fields.fmt    = instr_fmt_t'(s_fmt);
    fields.opcode = s_opcode;
    fields.rd     = s_rd;
    fields.rs1    = s_rs1;
    fields.rs2    = s_rs2;
    fields.funct3 = s_funct3;
    fields.funct7 = s_funct7;
    fields.imm    = s_imm;
  end

  riscv_instr_encoder u_encoder (
    .fields (fields),
    .word   (enc_word),
    .err    (enc_err)
  );

  assign base_aligned = i_base_addr & ALIGN_MSK;
  assign at_top       = (addr_q == TOP_ADDR);
  assign accept       = s_valid & s_ready;
  assign write_ok     = accept & ~enc_err;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start wins everywhere; last beats full so a last word at the top ends as DONE
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = LOAD;
    end else if (state_q == LOAD && accept) begin
      if (s_last)              state_d = DONE;
      else if (!enc_err && at_top) state_d = FULL;
    end
  end

  // Outputs decoded from state: stream handshake
  always_comb begin
    s_ready = (state_q == LOAD) && !i_start;
  end

  // Datapath: registered write port, address/count tracking and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_count     <= '0;
      o_done      <= 1'b0;
      o_full      <= 1'b0;
      o_err       <= 1'b0;
      addr_q      <= '0;
    end else begin
      o_mem_we <= write_ok;
      if (write_ok) begin
        o_mem_addr  <= addr_q;
        o_mem_wdata <= enc_word;
      end
      if (i_start) begin
        addr_q  <= base_aligned;
        o_count <= '0;
        o_done  <= 1'b0;
        o_full  <= 1'b0;
        o_err   <= 1'b0;
      end else if (accept) begin
        if (enc_err) begin
          o_err <= 1'b1;
        end else begin
          o_count <= o_count + (NB_ADDR-1)'(1);
          if (at_top) o_full <= 1'b1;
          else        addr_q <= addr_q + WORD_STEP;
        end
        if (s_last) o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
module tb_riscv_imem_loader;

  localparam int NB_ADDR = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [NB_ADDR-1:0] i_base_addr;
  logic               s_valid, s_ready, s_last;
  logic [2:0]         s_fmt, s_funct3;
  logic [6:0]         s_opcode, s_funct7;
  logic [4:0]         s_rd, s_rs1, s_rs2;
  logic [31:0]        s_imm;
  logic               o_mem_we;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [31:0]        o_mem_wdata;
  logic [NB_ADDR-2:0] o_count;
  logic               o_done, o_full, o_err;

  always #5 clk = ~clk;

  riscv_imem_loader #(.MEM_SIZE(128)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_fmt(s_fmt),
    .s_opcode(s_opcode), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_funct3(s_funct3), .s_funct7(s_funct7), .s_imm(s_imm),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_count(o_count), .o_done(o_done), .o_full(o_full), .o_err(o_err)
  );

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  vec_t        vecs[17];
  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr;
  int          exp_cnt;
  logic        exp_err_flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic e, input logic [31:0] w);
    vec_t v;
    v.name = n; v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_err = e; v.exp_word = w;
    return v;
  endfunction

  // Write monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (o_mem_we) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=0x%02h data=0x%08h required=none", o_mem_addr, o_mem_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(o_mem_addr), e.addr);
        chk("wr_data", o_mem_wdata, e.word);
      end
    end
  end

  task automatic drive(input vec_t v);
    s_fmt = v.fmt; s_opcode = v.op; s_rd = v.rd; s_rs1 = v.rs1; s_rs2 = v.rs2;
    s_funct3 = v.f3; s_funct7 = v.f7; s_imm = v.imm;
  endtask

  task automatic expect_accept(input vec_t v);
    exp_err_flag = exp_err_flag | v.exp_err;
    if (!v.exp_err) begin
      q.push_back('{addr: exp_addr, word: v.exp_word});
      exp_addr = exp_addr + 4;
      exp_cnt++;
    end
  endtask

  task automatic send(input vec_t v, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    drive(v);
    s_valid = 1'b1;
    s_last  = last;
    #1;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout %s actual=no_ready required=ready", v.name);
    end else begin
      expect_accept(v);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic post_chk(input string tag);
    @(negedge clk);
    #2;
    chk({tag, "_err"}, 32'(o_err), 32'(exp_err_flag));
    chk({tag, "_count"}, 32'(o_count), 32'(exp_cnt));
    chk({tag, "_pending"}, 32'(q.size()), 32'd0);
  endtask

  task automatic start(input logic [NB_ADDR-1:0] b);
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = b;
    @(negedge clk);
    i_start      = 1'b0;
    exp_addr     = 32'(b) & 32'h7C;
    exp_cnt      = 0;
    exp_err_flag = 1'b0;
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, 32'(o_mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
    chk({tag, "_count"}, 32'(o_count), 32'd0);
    chk({tag, "_flags"}, {29'd0, o_done, o_full, o_err}, 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vecs[0]  = mk("addi",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b0, 32'h00500093);
    vecs[1]  = mk("sw",      3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, -32'sd4,      1'b0, 32'hFE20AE23);
    vecs[2]  = mk("beq",     3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd8,      1'b0, 32'hFE000CE3);
    vecs[3]  = mk("jal",     3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        1'b0, 32'h008000EF);
    vecs[4]  = mk("b4096",   3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     1'b1, 32'h0);
    vecs[5]  = mk("add",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        1'b0, 32'h002081B3);
    vecs[6]  = mk("srai",    3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3,        1'b0, 32'h40335293);
    vecs[7]  = mk("lui",     3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0, 32'h123452B7);
    vecs[8]  = mk("u_low",   3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 1'b1, 32'h0);
    vecs[9]  = mk("i2048",   3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     1'b1, 32'h0);
    vecs[10] = mk("i_m2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd2048,   1'b0, 32'h80000093);
    vecs[11] = mk("slli32",  3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd32,       1'b1, 32'h0);
    vecs[12] = mk("fmt6",    3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b1, 32'h0);
    vecs[13] = mk("j_odd",   3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7,        1'b1, 32'h0);
    vecs[14] = mk("b4094",   3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     1'b0, 32'h7E000FE3);
    vecs[15] = mk("j_min",   3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd1048576, 1'b0, 32'h8000006F);
    vecs[16] = mk("s2047",   3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'd2047,     1'b0, 32'h7E002FA3);

    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; s_valid = 1'b0; s_last = 1'b0;
    drive(vecs[0]);
    exp_addr = 0; exp_cnt = 0; exp_err_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Encoding table, one instruction at a time from base 0
    start(7'h00);
    chk("start_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 17; i++) begin
      send(vecs[i], 1'b0);
      post_chk(vecs[i].name);
    end
    chk("table_done", 32'(o_done), 32'd0);

    // A write in flight during i_start still lands; start clears count and flags
    send(vecs[5], 1'b0);
    start(7'h7B);
    chk("restart_pending", 32'(q.size()), 32'd0);
    chk("restart_count", 32'(o_count), 32'd0);
    chk("restart_err", 32'(o_err), 32'd0);

    // Valid held near the top of memory: two words then full, no wrap
    @(negedge clk);
    drive(vecs[0]);
    s_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (s_ready) begin
        expect_accept(vecs[0]);
        acc++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    #2;
    chk("full_accepts", 32'(acc), 32'd2);
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_count", 32'(o_count), 32'd2);
    chk("full_done", 32'(o_done), 32'd0);
    chk("full_pending", 32'(q.size()), 32'd0);

    // Last word exactly at the top: both done and full
    start(7'h7C);
    send(vecs[1], 1'b1);
    @(negedge clk);
    #2;
    chk("top_last_done", 32'(o_done), 32'd1);
    chk("top_last_full", 32'(o_full), 32'd1);
    chk("top_last_ready", 32'(s_ready), 32'd0);

    // s_last on the third word
    start(7'h10);
    chk("clear_flags", {29'd0, o_done, o_full, o_err}, 32'd0);
    send(vecs[0], 1'b0);
    send(vecs[2], 1'b0);
    send(vecs[3], 1'b1);
    @(negedge clk);
    #2;
    chk("last_done", 32'(o_done), 32'd1);
    chk("last_ready", 32'(s_ready), 32'd0);
    chk("last_count", 32'(o_count), 32'd3);
    chk("last_pending", 32'(q.size()), 32'd0);
    start(7'h00);
    chk("clear_done", 32'(o_done), 32'd0);
    chk("clear_count", 32'(o_count), 32'd0);
    chk("clear_ready", 32'(s_ready), 32'd1);

    // Errored instruction carrying s_last still ends the load
    send(vecs[0], 1'b0);
    send(vecs[4], 1'b1);
    @(negedge clk);
    #2;
    chk("errlast_done", 32'(o_done), 32'd1);
    chk("errlast_err", 32'(o_err), 32'd1);
    chk("errlast_count", 32'(o_count), 32'd1);
    chk("errlast_pending", 32'(q.size()), 32'd0);

    // Reset while an accept is pending: it must be dropped
    start(7'h20);
    send(vecs[6], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(vecs[7]);
    s_valid = 1'b1;
    #1;
    chk("rst_pending_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    #2;
    chk_reset("midrst");
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_pending", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
